// File: rtl/prog_loader_if.sv
// Byte-stream and instruction-memory signals between the program loader and its surroundings.
interface prog_loader_if #(
  parameter int ADDR_W = 4
);
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, err
  );

  modport master (
    output start, in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, err
  );
endinterface

// File: rtl/prog_loader.sv
// Framed byte-stream loader for the 16-bit instruction memory; holds the core in reset until a frame loads.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte on every frame.
module prog_loader #(
  parameter int ADDR_W = 4
) (
  input  logic          clk,
  input  logic          reset,
  prog_loader_if.slave  bus
);

  localparam int unsigned CAP = 1 << ADDR_W;
  localparam int          CW  = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_HI,
    S_LO,
    S_WR,
`ifdef PROG_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     len_q, len_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]        chk_q, chk_d;
`endif
  logic              in_ready_q, we_q, hold_q, busy_q, done_q, err_q;
  logic              ready_d, busy_d;
  logic              xfer;

  assign xfer = bus.in_valid & in_ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    hi_d    = hi_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    chk_d   = chk_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (bus.start) begin
          state_d = S_LEN;
          cnt_d   = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
          chk_d   = '0;
`endif
        end
      end
      S_LEN: begin
        if (xfer) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          chk_d = bus.in_data;
`endif
          if (bus.in_data == 8'd0 || 32'(bus.in_data) > CAP) begin
            state_d = S_ERR;
          end else begin
            len_d   = CW'(bus.in_data);
            state_d = S_HI;
          end
        end
      end
      S_HI: begin
        if (xfer) begin
          hi_d    = bus.in_data;
`ifdef PROG_LOADER_CHECKSUM_EN
          chk_d   = chk_q ^ bus.in_data;
`endif
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (xfer) begin
          wdata_d = {hi_q, bus.in_data};
          addr_d  = cnt_q[ADDR_W-1:0];
`ifdef PROG_LOADER_CHECKSUM_EN
          chk_d   = chk_q ^ bus.in_data;
`endif
          state_d = S_WR;
        end
      end
      S_WR: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q + CW'(1) == len_q) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_HI;
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (xfer) state_d = (bus.in_data == chk_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet aligned with it.
  always_comb begin
    ready_d = 1'b0;
    busy_d  = 1'b0;
    case (state_d)
      S_LEN, S_HI, S_LO: begin
        ready_d = 1'b1;
        busy_d  = 1'b1;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHK: begin
        ready_d = 1'b1;
        busy_d  = 1'b1;
      end
`endif
      S_WR:    busy_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      hi_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      chk_q      <= '0;
`endif
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      hold_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      hi_q       <= hi_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      chk_q      <= chk_d;
`endif
      in_ready_q <= ready_d;
      we_q       <= (state_d == S_WR);
      hold_q     <= (state_d != S_DONE);
      busy_q     <= busy_d;
      done_q     <= (state_d == S_DONE);
      err_q      <= (state_d == S_ERR);
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.cpu_hold   = hold_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frames, length errors, checksum, gaps, mid-frame start and reset.
module tb_prog_loader;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  prog_loader_if #(.ADDR_W(AW)) bus();
  prog_loader #(.ADDR_W(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_fail = 0;
  logic [19:0] wr_log[$];
  logic [19:0] exp_log[$];
  logic [7:0]  frame[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk)
    if (reset && bus.imem_we) wr_log.push_back({bus.imem_addr, bus.imem_wdata});

  function automatic void add_chk();
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] x = 8'h00;
    foreach (frame[i]) x = x ^ frame[i];
    frame.push_back(x);
`endif
  endfunction

  // Called on a falling edge; returns on the falling edge after the byte is taken.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    repeat (gap) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("ready_wait", 32'(bus.in_ready), 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic check_writes(input string tag);
    check_eq({tag, "_nwr"}, wr_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size() && i < wr_log.size(); i++)
      check_eq({tag, "_wr"}, 32'(wr_log[i]), 32'(exp_log[i]));
  endtask

  task automatic run_frame(input string tag, input bit rnd_gap, input bit mid_start, input bit ok);
    wr_log.delete();
    pulse_start();
    check_eq({tag, "_busy_len"}, 32'(bus.busy), 1);
    for (int i = 0; i < frame.size(); i++) begin
      send_byte(frame[i], rnd_gap ? int'($urandom_range(1, 3)) : 0);
      if (mid_start && i == 2) pulse_start();
    end
`ifndef PROG_LOADER_CHECKSUM_EN
    if (ok) begin
      check_eq({tag, "_we_last"}, 32'(bus.imem_we), 1);
      check_eq({tag, "_done_early"}, 32'(bus.done), 0);
      check_eq({tag, "_hold_early"}, 32'(bus.cpu_hold), 1);
      @(negedge clk);
    end
`endif
    check_eq({tag, "_done"}, 32'(bus.done), 32'(ok));
    check_eq({tag, "_err"}, 32'(bus.err), 32'(!ok));
    check_eq({tag, "_hold"}, 32'(bus.cpu_hold), 32'(!ok));
    check_eq({tag, "_busy"}, 32'(bus.busy), 0);
    check_eq({tag, "_ready"}, 32'(bus.in_ready), 0);
    check_eq({tag, "_we"}, 32'(bus.imem_we), 0);
    check_writes(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst_hold", 32'(bus.cpu_hold), 1);
    check_eq("rst_ready", 32'(bus.in_ready), 0);
    check_eq("rst_done", 32'(bus.done), 0);
    check_eq("rst_err", 32'(bus.err), 0);
    check_eq("rst_we", 32'(bus.imem_we), 0);
    check_eq("rst_busy", 32'(bus.busy), 0);

    frame   = '{8'h02, 8'h20, 8'h05, 8'h80, 8'h07};
    add_chk();
    exp_log = '{{4'd0, 16'h2005}, {4'd1, 16'h8007}};
    run_frame("two_words", 1'b0, 1'b0, 1'b1);

`ifdef PROG_LOADER_CHECKSUM_EN
    frame   = '{8'h01, 8'h12, 8'h34, 8'h27};
    exp_log = '{{4'd0, 16'h1234}};
    run_frame("chk_good", 1'b0, 1'b0, 1'b1);
    frame   = '{8'h01, 8'h12, 8'h34, 8'h26};
    run_frame("chk_bad", 1'b0, 1'b0, 1'b0);
`endif

    frame = '{8'h00};
    exp_log.delete();
    run_frame("len_zero", 1'b0, 1'b0, 1'b0);
    frame = '{8'h11};
    run_frame("len_17", 1'b0, 1'b0, 1'b0);

    frame = '{8'h10};
    exp_log.delete();
    for (int i = 0; i < 16; i++) begin
      logic [7:0] hi, lo;
      hi = 8'(i);
      lo = 8'h5A + 8'(i);
      frame.push_back(hi);
      frame.push_back(lo);
      exp_log.push_back({4'(i), hi, lo});
    end
    add_chk();
    run_frame("full_16", 1'b0, 1'b0, 1'b1);

    frame   = '{8'h02, 8'h20, 8'h05, 8'h80, 8'h07};
    add_chk();
    exp_log = '{{4'd0, 16'h2005}, {4'd1, 16'h8007}};
    run_frame("gaps_start", 1'b1, 1'b1, 1'b1);

    wr_log.delete();
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h20, 0);
    send_byte(8'h05, 0);
    send_byte(8'h80, 0);
    reset = 1'b0;
    #1;
    check_eq("midrst_hold", 32'(bus.cpu_hold), 1);
    check_eq("midrst_ready", 32'(bus.in_ready), 0);
    check_eq("midrst_busy", 32'(bus.busy), 0);
    check_eq("midrst_we", 32'(bus.imem_we), 0);
    check_eq("midrst_addr", 32'(bus.imem_addr), 0);
    check_eq("midrst_wdata", 32'(bus.imem_wdata), 0);
    check_eq("midrst_nwr", wr_log.size(), 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    frame   = '{8'h01, 8'hAB, 8'hCD};
    add_chk();
    exp_log = '{{4'd0, 16'hABCD}};
    run_frame("after_rst", 1'b0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
